// File: rtl/mul8_dot_accumulator.sv
// mul8_dot_accumulator: sums a run of LEN unsigned 16-bit products into an ACC_W-bit
// accumulator and returns the dot product over a valid/ready handshake.
// Optional build macro MUL8_ACC_SATURATE_EN: when defined the accumulator clamps to
// all-ones on carry-out instead of wrapping. overflow is reported in both builds.
module mul8_dot_accumulator #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      product,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W:0]     sum;
    logic               xfer;

    // in_ready is decoded from state only, so xfer has no comb path back to in_ready
    assign xfer = in_valid && (state_q == StAccum);
    // One extra bit catches the carry out of the accumulator
    assign sum  = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, product};

    // State, accumulator, run counter and sticky overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = len;
                    state_d = (len != '0) ? StAccum : StDone;
                end
            end
            StAccum: begin
                if (xfer) begin
                    count_d = count_q - 1'b1;
                    acc_d   = sum[ACC_W-1:0];
                    if (sum[ACC_W]) begin
                        ovf_d = 1'b1;
`ifdef MUL8_ACC_SATURATE_EN
                        // Once clamped, any further add carries again and re-clamps
                        acc_d = '1;
`else
                        acc_d = sum[ACC_W-1:0];
`endif
                    end
                    if (count_q == {{(LEN_W - 1){1'b0}}, 1'b1}) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        in_ready  = (state_q == StAccum);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        acc_out   = (state_q == StDone) ? acc_q : '0;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_mul8_dot_accumulator.sv
// Testbench for mul8_dot_accumulator: a 24-bit and a 16-bit instance share stimulus
// and are checked against a whole-run arithmetic model of the dot product.
module tb_mul8_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic [15:0] product;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_ovf, a_busy;
    logic [23:0] a_acc_out;
    logic        b_in_ready, b_out_valid, b_ovf, b_busy;
    logic [15:0] b_acc_out;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] prod_q[$];

    // Observations collected by drive_run
    bit          obs_timeout, obs_lat, obs_rdy_done, obs_stable, obs_idle;
    logic [23:0] a_seen;
    logic [15:0] b_seen;
    logic        a_ovf_seen, b_ovf_seen;

    always #5 clk = ~clk;

    mul8_dot_accumulator #(.ACC_W(24), .LEN_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(a_in_ready), .product(product), .out_valid(a_out_valid),
        .out_ready(out_ready), .acc_out(a_acc_out), .overflow(a_ovf), .busy(a_busy)
    );

    mul8_dot_accumulator #(.ACC_W(16), .LEN_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
        .in_ready(b_in_ready), .product(product), .out_valid(b_out_valid),
        .out_ready(out_ready), .acc_out(b_acc_out), .overflow(b_ovf), .busy(b_busy)
    );

    // Model: exact sum of the run, then reduced to a w-bit result
    function automatic logic [31:0] exp_acc(input int w);
        longint unsigned s;
        longint unsigned mx;
        s  = 0;
        mx = (64'd1 << w) - 64'd1;
        foreach (prod_q[i]) s += 64'(prod_q[i]);
`ifdef MUL8_ACC_SATURATE_EN
        if (s > mx) return 32'(mx);
`endif
        return 32'(s & mx);
    endfunction

    function automatic logic exp_ovf(input int w);
        longint unsigned s;
        s = 0;
        foreach (prod_q[i]) s += 64'(prod_q[i]);
        return s > ((64'd1 << w) - 64'd1);
    endfunction

    // Runs one complete transaction from a negedge; gap idle cycles between products,
    // hold cycles of out_ready=0 in DONE, optional start pulse during the hold.
    task automatic drive_run(input int n, input int gap, input int hold, input bit poke);
        int idx, cyc, gap_cnt;
        bit rdy;
        obs_timeout = 0;
        obs_stable  = 1;
        start = 1'b1;
        len   = 8'(n);
        @(negedge clk);
        start = 1'b0;
        len   = 8'($urandom);
        idx = 0; cyc = 0; gap_cnt = 0;
        while (idx < n) begin
            if (cyc > n * (gap + 1) + 20) begin
                obs_timeout = 1;
                break;
            end
            if (gap_cnt > 0) begin
                in_valid = 1'b0;
                product  = 16'($urandom);
                gap_cnt--;
            end else begin
                in_valid = 1'b1;
                product  = prod_q[idx];
            end
            rdy = a_in_ready && b_in_ready;
            @(negedge clk);
            cyc++;
            if (in_valid && rdy) begin
                idx++;
                gap_cnt = gap;
            end
        end
        in_valid     = 1'b0;
        obs_lat      = a_out_valid && b_out_valid;
        obs_rdy_done = a_in_ready || b_in_ready;
        a_seen       = a_acc_out;
        b_seen       = b_acc_out;
        a_ovf_seen   = a_ovf;
        b_ovf_seen   = b_ovf;
        out_ready    = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = poke && (h == 1);
            len   = 8'd3;
            @(negedge clk);
            if (!a_out_valid || !b_out_valid || a_acc_out !== a_seen || b_acc_out !== b_seen
                || a_ovf !== a_ovf_seen || b_ovf !== b_ovf_seen)
                obs_stable = 0;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        obs_idle  = !a_out_valid && !b_out_valid && !a_busy && !b_busy
                    && a_acc_out == 24'd0 && b_acc_out == 16'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; product = 16'd0;
        out_ready = 1'b0;
        #2;
        n_vec++;
        if ({a_in_ready, a_out_valid, a_ovf, a_busy, a_acc_out} !== 28'd0 ||
            {b_in_ready, b_out_valid, b_ovf, b_busy, b_acc_out} !== 20'd0) begin
            n_err++;
            $display("FAIL reset_outputs: a=%h b=%h, want all zero",
                     {a_in_ready, a_out_valid, a_ovf, a_busy, a_acc_out},
                     {b_in_ready, b_out_valid, b_ovf, b_busy, b_acc_out});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy a=%b b=%b out_valid=%b, want 0 0 0",
                     a_busy, b_busy, a_out_valid);
        end
    endtask

    task automatic test_basic();
        prod_q = '{16'd100, 16'd200, 16'd300};
        drive_run(3, 0, 0, 0);
        n_vec++;
        if (obs_timeout || !obs_lat) begin
            n_err++;
            $display("FAIL basic_latency: timeout=%b out_valid=%b, want 0 1", obs_timeout, obs_lat);
        end
        n_vec++;
        if (a_seen !== 24'd600 || a_ovf_seen !== 1'b0) begin
            n_err++;
            $display("FAIL basic_sum: acc=%0d ovf=%b, want 600 0", a_seen, a_ovf_seen);
        end
        n_vec++;
        if (!obs_idle) begin
            n_err++;
            $display("FAIL basic_one_cycle_valid: idle_after=%b, want 1", obs_idle);
        end
    endtask

    task automatic test_empty();
        prod_q.delete();
        drive_run(0, 0, 0, 0);
        n_vec++;
        if (!obs_lat || a_seen !== 24'd0 || a_ovf_seen !== 1'b0 || obs_rdy_done) begin
            n_err++;
            $display("FAIL empty_run: valid=%b acc=%0d ovf=%b in_ready=%b, want 1 0 0 0",
                     obs_lat, a_seen, a_ovf_seen, obs_rdy_done);
        end
    endtask

    task automatic test_overflow();
        prod_q = '{16'hFFFF, 16'h0002};
        drive_run(2, 0, 0, 0);
        n_vec++;
`ifdef MUL8_ACC_SATURATE_EN
        if (b_seen !== 16'hFFFF || b_ovf_seen !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_16: acc=%h ovf=%b, want ffff 1", b_seen, b_ovf_seen);
        end
`else
        if (b_seen !== 16'h0001 || b_ovf_seen !== 1'b1) begin
            n_err++;
            $display("FAIL overflow_16: acc=%h ovf=%b, want 0001 1", b_seen, b_ovf_seen);
        end
`endif
        n_vec++;
        if (a_seen !== 24'h010001 || a_ovf_seen !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_24: acc=%h ovf=%b, want 010001 0", a_seen, a_ovf_seen);
        end
        prod_q = '{16'd5};
        drive_run(1, 0, 0, 0);
        n_vec++;
        if (b_seen !== 16'd5 || b_ovf_seen !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_clear: acc=%0d ovf=%b, want 5 0", b_seen, b_ovf_seen);
        end
    endtask

    task automatic test_backpressure();
        prod_q = '{16'd7, 16'd9};
        drive_run(2, 0, 5, 1);
        n_vec++;
        if (a_seen !== 24'd16 || b_seen !== 16'd16) begin
            n_err++;
            $display("FAIL backpressure_sum: acc a=%0d b=%0d, want 16 16", a_seen, b_seen);
        end
        n_vec++;
        if (!obs_stable) begin
            n_err++;
            $display("FAIL backpressure_stable: stable=%b, want 1", obs_stable);
        end
        n_vec++;
        if (!obs_idle) begin
            n_err++;
            $display("FAIL backpressure_idle: idle_after=%b, want 1", obs_idle);
        end
    endtask

    task automatic test_gaps();
        prod_q = '{16'd1, 16'd2, 16'd3, 16'd4};
        drive_run(4, 3, 0, 0);
        n_vec++;
        if (obs_timeout || !obs_lat || a_seen !== 24'd10) begin
            n_err++;
            $display("FAIL gaps_sum: timeout=%b valid=%b acc=%0d, want 0 1 10",
                     obs_timeout, obs_lat, a_seen);
        end
    endtask

    task automatic test_mid_reset();
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            product  = 16'(10 * (i + 1));
            @(negedge clk);
        end
        product = 16'd30;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({a_in_ready, a_out_valid, a_ovf, a_busy, a_acc_out} !== 28'd0 ||
            {b_in_ready, b_out_valid, b_ovf, b_busy, b_acc_out} !== 20'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: a=%h b=%h, want all zero",
                     {a_in_ready, a_out_valid, a_ovf, a_busy, a_acc_out},
                     {b_in_ready, b_out_valid, b_ovf, b_busy, b_acc_out});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (a_busy || b_busy || a_out_valid || b_out_valid) begin
            n_err++;
            $display("FAIL midreset_idle: busy=%b%b out_valid=%b%b, want 00 00",
                     a_busy, b_busy, a_out_valid, b_out_valid);
        end
        prod_q = '{16'd42};
        drive_run(1, 0, 0, 0);
        n_vec++;
        if (a_seen !== 24'd42 || b_seen !== 16'd42) begin
            n_err++;
            $display("FAIL midreset_fresh: acc a=%0d b=%0d, want 42 42", a_seen, b_seen);
        end
    endtask

    task automatic test_random();
        int n;
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, 6);
            prod_q.delete();
            for (int i = 0; i < n; i++) prod_q.push_back(16'($urandom));
            drive_run(n, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom));
            n_vec++;
            if (obs_timeout || !obs_lat || !obs_stable || !obs_idle) begin
                n_err++;
                $display("FAIL rand%0d_handshake: timeout=%b valid=%b stable=%b idle=%b",
                         r, obs_timeout, obs_lat, obs_stable, obs_idle);
            end
            n_vec++;
            if ({8'd0, a_seen} !== exp_acc(24) || a_ovf_seen !== exp_ovf(24)) begin
                n_err++;
                $display("FAIL rand%0d_acc24: acc=%h ovf=%b, want %h %b",
                         r, a_seen, a_ovf_seen, exp_acc(24), exp_ovf(24));
            end
            n_vec++;
            if ({16'd0, b_seen} !== exp_acc(16) || b_ovf_seen !== exp_ovf(16)) begin
                n_err++;
                $display("FAIL rand%0d_acc16: acc=%h ovf=%b, want %h %b",
                         r, b_seen, b_ovf_seen, exp_acc(16), exp_ovf(16));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_overflow();
        test_backpressure();
        test_gaps();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
